// File: rtl/gps_ch_sched.sv
// gps_ch_sched: Wishbone master that services gps_multichannel correlator channels.
// Programs a channel's setup registers on request, otherwise polls STATUS round-robin
// and, when a dump is ready, streams the six accumulators out and re-arms the channel.
module gps_ch_sched #(
    parameter int unsigned NUM_CH    = 2,
    parameter logic [31:0] CH_BASE   = 32'h0000_0A00,
    parameter logic [31:0] CH_STRIDE = 32'h0000_0100,
    parameter int unsigned POLL_GAP  = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                                     wb_clk_i,
    input  logic                                     wb_rst_i,
    input  logic                                     en_i,
    input  logic                                     cfg_req_i,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch_i,
    input  logic [31:0]                              cfg_code_frq_i,
    input  logic [31:0]                              cfg_carr_frq_i,
    input  logic [31:0]                              cfg_thresh_i,
    input  logic [31:0]                              cfg_conf_i,
    output logic                                     cfg_ack_o,
    output logic [31:0]                              wbm_adr_o,
    output logic [31:0]                              wbm_dat_o,
    input  logic [31:0]                              wbm_dat_i,
    output logic                                     wbm_we_o,
    output logic [3:0]                               wbm_sel_o,
    output logic                                     wbm_cyc_o,
    output logic                                     wbm_stb_o,
    input  logic                                     wbm_ack_i,
    output logic                                     dump_vld_o,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] dump_ch_o,
    output logic [2:0]                               dump_idx_o,
    output logic [31:0]                              dump_dat_o,
    output logic                                     tmo_o
);

    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam int unsigned GAP_W = $clog2(POLL_GAP + 1) + 1;

    localparam logic [31:0] OFF_CODE_FRQ = 32'h00;
    localparam logic [31:0] OFF_CARR_FRQ = 32'h04;
    localparam logic [31:0] OFF_CODE_OFS = 32'h08;
    localparam logic [31:0] OFF_CARR_OFS = 32'h0C;
    localparam logic [31:0] OFF_THRESH   = 32'h10;
    localparam logic [31:0] OFF_CONFG    = 32'h14;
    localparam logic [31:0] OFF_ACC0     = 32'h18;
    localparam logic [31:0] OFF_STATUS   = 32'h30;

    typedef enum logic [2:0] {
        IDLE,
        CFG_WR,
        POLL_RD,
        POLL_WAIT,
        DUMP_RD,
        CLR_WR
    } state_e;

    state_e            state_q, state_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [31:0]       stat_q, stat_d;
    logic [CH_W-1:0]   cfg_ch_q, cfg_ch_d;
    logic [31:0]       code_q, code_d, carr_q, carr_d, thr_q, thr_d, conf_q, conf_d;
    logic [31:0]       adr_q, adr_d, wdat_q, wdat_d;
    logic              we_q, we_d, cyc_q, cyc_d;
    logic [3:0]        sel_q, sel_d;
    logic              cfg_ack_q, cfg_ack_d;
    logic              dump_vld_q, dump_vld_d;
    logic [CH_W-1:0]   dump_ch_q, dump_ch_d;
    logic [2:0]        dump_idx_q, dump_idx_d;
    logic [31:0]       dump_dat_q, dump_dat_d;
    logic              tmo_q, tmo_d;

    logic [CH_W-1:0]   rr_next;
    logic [CH_W-1:0]   bus_ch;
    logic [31:0]       bus_base;
    logic [31:0]       off;
    logic [31:0]       wd;
    logic              wr;
    logic              is_bus;
    logic              done;

    assign rr_next  = (rr_q == CH_W'(NUM_CH - 1)) ? '0 : rr_q + CH_W'(1);
    assign bus_ch   = (state_q == CFG_WR) ? cfg_ch_q : rr_q;
    assign bus_base = CH_BASE + 32'(bus_ch) * CH_STRIDE;
    assign done     = cyc_q & wbm_ack_i;

    // Sequencer: per-state transaction selection, then common launch/ack/timeout handling.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        gap_d      = gap_q;
        stat_d     = stat_q;
        cfg_ch_d   = cfg_ch_q;
        code_d     = code_q;
        carr_d     = carr_q;
        thr_d      = thr_q;
        conf_d     = conf_q;
        adr_d      = adr_q;
        wdat_d     = wdat_q;
        we_d       = we_q;
        cyc_d      = cyc_q;
        sel_d      = sel_q;
        cfg_ack_d  = 1'b0;
        dump_vld_d = 1'b0;
        dump_ch_d  = dump_ch_q;
        dump_idx_d = dump_idx_q;
        dump_dat_d = dump_dat_q;
        tmo_d      = 1'b0;
        off        = 32'h0;
        wd         = 32'h0;
        wr         = 1'b0;
        is_bus     = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_req_i) begin
                    state_d  = CFG_WR;
                    cnt_d    = 3'd0;
                    cfg_ch_d = cfg_ch_i;
                    code_d   = cfg_code_frq_i;
                    carr_d   = cfg_carr_frq_i;
                    thr_d    = cfg_thresh_i;
                    conf_d   = cfg_conf_i;
                end else if (en_i) begin
                    state_d = POLL_RD;
                end
            end
            CFG_WR: begin
                is_bus = 1'b1;
                wr     = 1'b1;
                case (cnt_q)
                    3'd0:    begin off = OFF_CARR_FRQ; wd = carr_q; end
                    3'd1:    begin off = OFF_CODE_FRQ; wd = code_q; end
                    3'd2:    begin off = OFF_THRESH;   wd = thr_q;  end
                    3'd3:    begin off = OFF_CONFG;    wd = conf_q; end
                    3'd4:    begin off = OFF_CARR_OFS; wd = 32'h0;  end
                    default: begin off = OFF_CODE_OFS; wd = 32'h0;  end
                endcase
                if (done) begin
                    if (cnt_q == 3'd5) begin
                        cfg_ack_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            POLL_RD: begin
                is_bus = 1'b1;
                off    = OFF_STATUS;
                if (done) begin
                    stat_d = wbm_dat_i;
                    cnt_d  = 3'd0;
                    gap_d  = '0;
                    state_d = wbm_dat_i[0] ? DUMP_RD : POLL_WAIT;
                end
            end
            POLL_WAIT: begin
                if ((32'(gap_q) + 32'd1) >= POLL_GAP) begin
                    rr_d    = rr_next;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            DUMP_RD: begin
                is_bus = 1'b1;
                off    = OFF_ACC0 + 32'({cnt_q, 2'b00});
                if (done) begin
                    dump_vld_d = 1'b1;
                    dump_ch_d  = rr_q;
                    dump_idx_d = cnt_q;
                    dump_dat_d = wbm_dat_i;
                    if (cnt_q == 3'd5) begin
                        state_d = CLR_WR;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            CLR_WR: begin
                is_bus = 1'b1;
                wr     = 1'b1;
                off    = OFF_STATUS;
                wd     = {stat_q[31:1], 1'b0};
                if (done) begin
                    rr_d    = rr_next;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // One transaction at a time; the cycle after an ack is always idle.
        if (is_bus) begin
            if (!cyc_q) begin
                cyc_d     = 1'b1;
                sel_d     = 4'hF;
                we_d      = wr;
                adr_d     = bus_base + off;
                wdat_d    = wd;
                tmo_cnt_d = '0;
            end else if (wbm_ack_i) begin
                cyc_d = 1'b0;
                sel_d = 4'h0;
                we_d  = 1'b0;
            end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                cyc_d   = 1'b0;
                sel_d   = 4'h0;
                we_d    = 1'b0;
                tmo_d   = 1'b1;
                rr_d    = rr_next;
                state_d = IDLE;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            cnt_q      <= '0;
            tmo_cnt_q  <= '0;
            gap_q      <= '0;
            stat_q     <= '0;
            cfg_ch_q   <= '0;
            code_q     <= '0;
            carr_q     <= '0;
            thr_q      <= '0;
            conf_q     <= '0;
            adr_q      <= '0;
            wdat_q     <= '0;
            we_q       <= 1'b0;
            cyc_q      <= 1'b0;
            sel_q      <= '0;
            cfg_ack_q  <= 1'b0;
            dump_vld_q <= 1'b0;
            dump_ch_q  <= '0;
            dump_idx_q <= '0;
            dump_dat_q <= '0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            gap_q      <= gap_d;
            stat_q     <= stat_d;
            cfg_ch_q   <= cfg_ch_d;
            code_q     <= code_d;
            carr_q     <= carr_d;
            thr_q      <= thr_d;
            conf_q     <= conf_d;
            adr_q      <= adr_d;
            wdat_q     <= wdat_d;
            we_q       <= we_d;
            cyc_q      <= cyc_d;
            sel_q      <= sel_d;
            cfg_ack_q  <= cfg_ack_d;
            dump_vld_q <= dump_vld_d;
            dump_ch_q  <= dump_ch_d;
            dump_idx_q <= dump_idx_d;
            dump_dat_q <= dump_dat_d;
            tmo_q      <= tmo_d;
        end
    end

    assign cfg_ack_o  = cfg_ack_q;
    assign wbm_adr_o  = adr_q;
    assign wbm_dat_o  = wdat_q;
    assign wbm_we_o   = we_q;
    assign wbm_sel_o  = sel_q;
    assign wbm_cyc_o  = cyc_q;
    assign wbm_stb_o  = cyc_q;
    assign dump_vld_o = dump_vld_q;
    assign dump_ch_o  = dump_ch_q;
    assign dump_idx_o = dump_idx_q;
    assign dump_dat_o = dump_dat_q;
    assign tmo_o      = tmo_q;

endmodule

// File: tb/tb_gps_ch_sched.sv
// Scoreboard bench for gps_ch_sched: a Wishbone slave model checks every bus
// transaction and every dump word against queued expectations.
module tb_gps_ch_sched;

    localparam int unsigned NUM_CH   = 2;
    localparam int unsigned POLL_GAP = 4;
    localparam int unsigned TIMEOUT  = 255;
    localparam logic [31:0] NO_ADR   = 32'hFFFF_FFFF;

    logic        clk;
    logic        wb_rst_i;
    logic        en_i;
    logic        cfg_req_i;
    logic [0:0]  cfg_ch_i;
    logic [31:0] cfg_code_frq_i, cfg_carr_frq_i, cfg_thresh_i, cfg_conf_i;
    logic        cfg_ack_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_cyc_o, wbm_stb_o, wbm_ack_i;
    logic        dump_vld_o;
    logic [0:0]  dump_ch_o;
    logic [2:0]  dump_idx_o;
    logic [31:0] dump_dat_o;
    logic        tmo_o;

    gps_ch_sched #(
        .NUM_CH(NUM_CH), .CH_BASE(32'h0A00), .CH_STRIDE(32'h0100),
        .POLL_GAP(POLL_GAP), .TIMEOUT(TIMEOUT)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .en_i(en_i),
        .cfg_req_i(cfg_req_i), .cfg_ch_i(cfg_ch_i),
        .cfg_code_frq_i(cfg_code_frq_i), .cfg_carr_frq_i(cfg_carr_frq_i),
        .cfg_thresh_i(cfg_thresh_i), .cfg_conf_i(cfg_conf_i), .cfg_ack_o(cfg_ack_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
        .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o), .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o), .wbm_ack_i(wbm_ack_i),
        .dump_vld_o(dump_vld_o), .dump_ch_o(dump_ch_o), .dump_idx_o(dump_idx_o),
        .dump_dat_o(dump_dat_o), .tmo_o(tmo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } bus_t;

    typedef struct packed {
        logic [0:0]  ch;
        logic [2:0]  idx;
        logic [31:0] dat;
    } dump_t;

    bus_t        exp_q[$];
    dump_t       dmp_q[$];
    logic [31:0] stat_m [NUM_CH];
    logic [31:0] acc_m  [NUM_CH][6];
    logic [31:0] noack_adr;
    int          n_vec, n_err;
    int          cyc_cnt, t_rise, t_end, n_tmo, n_cfg_ack;
    bit          have_end, gap_arm, run_en, prev_cyc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_bus(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        bus_t b;
        b.we = we; b.adr = adr; b.dat = dat;
        exp_q.push_back(b);
    endtask

    task automatic push_dump(input logic [0:0] ch, input logic [2:0] idx, input logic [31:0] dat);
        dump_t d;
        d.ch = ch; d.idx = idx; d.dat = dat;
        dmp_q.push_back(d);
    endtask

    function automatic logic [31:0] slv_rd(input logic [31:0] adr);
        logic [31:0] rel;
        int          ch;
        int          off;
        rel = adr - 32'h0A00;
        ch  = int'(rel >> 8);
        off = int'(rel[7:0]);
        if (rel >= 32'(NUM_CH * 256)) return 32'h0;
        if (off == 'h30) return stat_m[ch];
        if (off >= 'h18 && off <= 'h2C) return acc_m[ch][(off - 'h18) / 4];
        return 32'h0;
    endfunction

    // Slave model: one-cycle ack, transaction checking, dump and timeout monitoring.
    initial begin
        wbm_ack_i = 1'b0; wbm_dat_i = 32'h0; en_i = 1'b0;
        forever begin
            @(negedge clk);
            cyc_cnt++;
            if (wb_rst_i) begin
                wbm_ack_i = 1'b0; prev_cyc = 1'b0; have_end = 1'b0; gap_arm = 1'b0;
            end else begin
                if (wbm_cyc_o && !prev_cyc) begin
                    t_rise = cyc_cnt;
                    check("sel_stb", {60'h0, wbm_sel_o}, 64'hF);
                    check("stb", {63'h0, wbm_stb_o}, 64'h1);
                    if (have_end) check("idle_gap", {63'h0, (cyc_cnt - t_end - 1) >= 1}, 64'h1);
                    if (gap_arm) check("poll_gap", {63'h0, (cyc_cnt - t_end - 1) >= int'(POLL_GAP)}, 64'h1);
                    gap_arm = 1'b0;
                end
                if (wbm_ack_i) begin
                    wbm_ack_i = 1'b0;
                end else if (wbm_cyc_o && wbm_adr_o != noack_adr) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_txn", {31'h0, wbm_we_o, wbm_adr_o}, 64'h0);
                    end else begin
                        bus_t e;
                        e = exp_q.pop_front();
                        check("adr", {32'h0, wbm_adr_o}, {32'h0, e.adr});
                        check("we", {63'h0, wbm_we_o}, {63'h0, e.we});
                        if (e.we) check("wdat", {32'h0, wbm_dat_o}, {32'h0, e.dat});
                    end
                    wbm_dat_i = slv_rd(wbm_adr_o);
                    if (wbm_we_o && wbm_adr_o[7:0] == 8'h30 && (wbm_adr_o - 32'h0A00) < 32'(NUM_CH * 256))
                        stat_m[int'((wbm_adr_o - 32'h0A00) >> 8)] = wbm_dat_o;
                    gap_arm   = !wbm_we_o && wbm_adr_o[7:0] == 8'h30 && !wbm_dat_i[0];
                    wbm_ack_i = 1'b1;
                    t_end     = cyc_cnt;
                    have_end  = 1'b1;
                end
                if (tmo_o) begin
                    n_tmo++;
                    check("tmo_latency", 64'(cyc_cnt - t_rise), 64'(TIMEOUT));
                    check("tmo_cyc_low", {63'h0, wbm_cyc_o}, 64'h0);
                end
                if (cfg_ack_o) n_cfg_ack++;
                if (dump_vld_o) begin
                    if (dmp_q.size() == 0) begin
                        check("unexpected_dump", {28'h0, dump_ch_o, dump_idx_o, dump_dat_o}, 64'h0);
                    end else begin
                        dump_t d;
                        d = dmp_q.pop_front();
                        check("dump_ch", {63'h0, dump_ch_o}, {63'h0, d.ch});
                        check("dump_idx", {61'h0, dump_idx_o}, {61'h0, d.idx});
                        check("dump_dat", {32'h0, dump_dat_o}, {32'h0, d.dat});
                    end
                end
                prev_cyc = wbm_cyc_o;
            end
            en_i = run_en && (exp_q.size() != 0);
        end
    end

    task automatic do_reset();
        wb_rst_i = 1'b1;
        repeat (2) @(negedge clk);
        wb_rst_i = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_bus"}, {wbm_adr_o, wbm_dat_o}, 64'h0);
        check({tag, "_ctl"}, {50'h0, cfg_ack_o, wbm_we_o, wbm_sel_o, wbm_cyc_o, wbm_stb_o,
                              dump_vld_o, dump_ch_o, dump_idx_o, tmo_o}, 64'h0);
        check({tag, "_dump"}, {32'h0, dump_dat_o}, 64'h0);
    endtask

    task automatic wait_drain(input string tag, input int max);
        int i;
        for (i = 0; i < max && (exp_q.size() != 0 || dmp_q.size() != 0); i++) @(negedge clk);
        check(tag, 64'(exp_q.size() + dmp_q.size()), 64'h0);
        repeat (20) @(negedge clk);
    endtask

    task automatic wait_cfg_ack(input string tag, input int max);
        int i;
        for (i = 0; i < max && !cfg_ack_o; i++) @(negedge clk);
        check(tag, {63'h0, cfg_ack_o}, 64'h1);
        cfg_req_i = 1'b0;
    endtask

    task automatic push_cfg(input logic [31:0] base, input logic [31:0] code, input logic [31:0] carr,
                            input logic [31:0] thr, input logic [31:0] conf);
        push_bus(1'b1, base + 32'h04, carr);
        push_bus(1'b1, base + 32'h00, code);
        push_bus(1'b1, base + 32'h10, thr);
        push_bus(1'b1, base + 32'h14, conf);
        push_bus(1'b1, base + 32'h0C, 32'h0);
        push_bus(1'b1, base + 32'h08, 32'h0);
    endtask

    initial begin
        wb_rst_i = 1'b1; cfg_req_i = 1'b0; cfg_ch_i = 1'b0; run_en = 1'b0;
        cfg_code_frq_i = 32'h0; cfg_carr_frq_i = 32'h0; cfg_thresh_i = 32'h0; cfg_conf_i = 32'h0;
        noack_adr = NO_ADR;
        for (int c = 0; c < NUM_CH; c++) begin
            stat_m[c] = 32'h0;
            for (int k = 0; k < 6; k++) acc_m[c][k] = 32'h0;
        end
        @(negedge clk);
        check_outputs_zero("reset");
        do_reset();

        // Program channel 0.
        cfg_ch_i = 1'b0; cfg_code_frq_i = 32'h16EA4A8C; cfg_carr_frq_i = 32'h0;
        cfg_thresh_i = 32'h2710; cfg_conf_i = 32'h1409A1BE;
        push_cfg(32'h0A00, 32'h16EA4A8C, 32'h0, 32'h2710, 32'h1409A1BE);
        cfg_req_i = 1'b1;
        wait_cfg_ack("cfg0_ack", 200);
        wait_drain("cfg0_drain", 200);
        check("cfg0_ack_count", 64'(n_cfg_ack), 64'd1);

        // Idle polling, alternating channels.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            push_bus(1'b0, 32'h0A30, 32'h0);
            push_bus(1'b0, 32'h0B30, 32'h0);
        end
        run_en = 1'b1;
        wait_drain("poll_drain", 400);
        run_en = 1'b0;

        // Dump on channel 1.
        do_reset();
        stat_m[1] = 32'h3;
        for (int k = 0; k < 6; k++) acc_m[1][k] = 32'(k + 1);
        push_bus(1'b0, 32'h0A30, 32'h0);
        push_bus(1'b0, 32'h0B30, 32'h0);
        for (int k = 0; k < 6; k++) begin
            push_bus(1'b0, 32'h0B18 + 32'(4 * k), 32'h0);
            push_dump(1'b1, 3'(k), 32'(k + 1));
        end
        push_bus(1'b1, 32'h0B30, 32'h2);
        push_bus(1'b0, 32'h0A30, 32'h0);
        run_en = 1'b1;
        wait_drain("dump1_drain", 600);
        run_en = 1'b0;
        check("dump1_status_cleared", {32'h0, stat_m[1]}, 64'h2);

        // Slave stalls the third accumulator read of channel 0.
        do_reset();
        stat_m[0] = 32'h1;
        for (int k = 0; k < 6; k++) acc_m[0][k] = 32'h100 + 32'(k);
        noack_adr = 32'h0A20;
        push_bus(1'b0, 32'h0A30, 32'h0);
        push_bus(1'b0, 32'h0A18, 32'h0); push_dump(1'b0, 3'd0, 32'h100);
        push_bus(1'b0, 32'h0A1C, 32'h0); push_dump(1'b0, 3'd1, 32'h101);
        push_bus(1'b0, 32'h0B30, 32'h0);
        run_en = 1'b1;
        wait_drain("tmo_drain", 2000);
        run_en = 1'b0;
        noack_adr = NO_ADR;
        check("tmo_count", 64'(n_tmo), 64'd1);
        check("tmo_no_clear", {32'h0, stat_m[0]}, 64'h1);

        // Config request raised mid-dump waits for the STATUS clear.
        do_reset();
        push_bus(1'b0, 32'h0A30, 32'h0);
        for (int k = 0; k < 6; k++) begin
            push_bus(1'b0, 32'h0A18 + 32'(4 * k), 32'h0);
            push_dump(1'b0, 3'(k), 32'h100 + 32'(k));
        end
        push_bus(1'b1, 32'h0A30, 32'h0);
        push_cfg(32'h0B00, 32'hCAFE0001, 32'h12345678, 32'h00000042, 32'h00000007);
        cfg_ch_i = 1'b1; cfg_code_frq_i = 32'hCAFE0001; cfg_carr_frq_i = 32'h12345678;
        cfg_thresh_i = 32'h42; cfg_conf_i = 32'h7;
        run_en = 1'b1;
        for (int i = 0; i < 200 && !dump_vld_o; i++) @(negedge clk);
        check("mid_dump_seen", {63'h0, dump_vld_o}, 64'h1);
        cfg_req_i = 1'b1;
        wait_cfg_ack("cfg1_ack", 600);
        wait_drain("cfg1_drain", 200);
        run_en = 1'b0;
        check("cfg1_ack_count", 64'(n_cfg_ack), 64'd2);
        check("cfg1_status_cleared", {32'h0, stat_m[0]}, 64'h0);

        // Reset while a STATUS read of channel 1 is outstanding.
        do_reset();
        noack_adr = 32'h0B30;
        push_bus(1'b0, 32'h0A30, 32'h0);
        push_bus(1'b0, 32'h0B30, 32'h0);
        run_en = 1'b1;
        for (int i = 0; i < 200 && !(wbm_cyc_o && wbm_adr_o == 32'h0B30); i++) @(negedge clk);
        check("rst_stall_seen", {63'h0, wbm_cyc_o}, 64'h1);
        repeat (3) @(negedge clk);
        wb_rst_i = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_outputs_zero("midrst");
        noack_adr = NO_ADR;
        push_bus(1'b0, 32'h0A30, 32'h0);
        wb_rst_i = 1'b0;
        wait_drain("midrst_drain", 200);
        run_en = 1'b0;
        check("final_tmo_count", 64'(n_tmo), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
